wb_bus_ctrl: RTL and testbench



---
 rtl/wb_bus_ctrl_pkg.sv | 46 ++++
 rtl/wb_timeout_cnt.sv | 40 ++++
 rtl/wb_bus_ctrl.sv | 179 +++++++++++++++++
 tb/tb_wb_bus_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_bus_ctrl_pkg.sv
// Shared types, widths and default decode constants for the user-side Wishbone controller.
package wb_bus_ctrl_pkg;

  localparam int unsigned ADR_W  = 32;
  localparam int unsigned DAT_W  = 32;
  localparam int unsigned BASE_W = 12;

  localparam logic [BASE_W-1:0] BRAM_BASE_DEF = 12'h380;
  localparam logic [BASE_W-1:0] UART_BASE_DEF = 12'h300;
  localparam logic [DAT_W-1:0]  ERR_DATA_DEF  = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    IDLE,
    BRAM_WAIT,
    UART_WAIT,
    ACK,
    ERR_ACK
  } state_e;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_BRAM,
    SEL_UART
  } sel_e;

  // Request captured when a cycle is accepted in IDLE.
  typedef struct packed {
    logic [ADR_W-1:0] adr;
    logic             we;
  } wb_req_t;

  // Slave select from the top address bits.
  function automatic sel_e decode_sel(input logic [BASE_W-1:0] adr_top,
                                      input logic [BASE_W-1:0] bram_base,
                                      input logic [BASE_W-1:0] uart_base);
    sel_e sel;
    sel = SEL_NONE;
    if (adr_top == bram_base) begin
      sel = SEL_BRAM;
    end else if (adr_top == uart_base) begin
      sel = SEL_UART;
    end
    return sel;
  endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// Wait-state timeout counter: cleared on wait entry, counts enabled cycles and
// raises expire_o during the LIMIT-th consecutive enabled cycle.
module wb_timeout_cnt #(
  parameter int unsigned LIMIT = 255,
  parameter int unsigned W     = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         expire_q, expire_d;

  // cnt_q holds the number of wait cycles already completed before the current one.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expire_q) begin
      cnt_d = cnt_q + W'(1);
    end
    expire_d = (cnt_d == W'(LIMIT - 1));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      expire_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      expire_q <= expire_d;
    end
  end

  assign expire_o = expire_q;

endmodule

// File: rtl/wb_bus_ctrl.sv
// Registered Wishbone slave-side controller routing Caravel cycles to the BRAM and UART.
// Optional wait-state timeout is enabled by defining WB_TIMEOUT_EN.
module wb_bus_ctrl
  import wb_bus_ctrl_pkg::*;
#(
  parameter logic [BASE_W-1:0] BRAM_BASE      = BRAM_BASE_DEF,
  parameter logic [BASE_W-1:0] UART_BASE      = UART_BASE_DEF,
  parameter int unsigned       TIMEOUT_CYCLES = 255,
  parameter int unsigned       TO_W           = 8,
  parameter logic [DAT_W-1:0]  ERR_DATA       = ERR_DATA_DEF
) (
  input  logic             wb_clk_i,
  input  logic             wb_rstn_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_we_i,
  input  logic [ADR_W-1:0] wbs_adr_i,
  output logic             wbs_ack_o,
  output logic [DAT_W-1:0] wbs_dat_o,
  output logic             cyc_bram_o,
  output logic             stb_bram_o,
  input  logic             wbs_ack_bram,
  input  logic [DAT_W-1:0] wbs_dat_o_bram,
  output logic             cyc_uart_o,
  output logic             stb_uart_o,
  input  logic             wbs_ack_uart,
  input  logic [DAT_W-1:0] wbs_dat_o_uart,
  output logic             err_flag_o,
  output logic [ADR_W-1:0] err_adr_o,
  input  logic             err_clr_i
);

  if (TIMEOUT_CYCLES < 1 || 64'(TIMEOUT_CYCLES) >= (64'd1 << TO_W)) begin : g_bad_timeout_cfg
    $error("wb_bus_ctrl: TIMEOUT_CYCLES must lie in 1..2**TO_W-1");
  end

  state_e           state_q, state_d;
  wb_req_t          req_q, req_d;
  logic             bram_q, bram_d;
  logic             uart_q, uart_d;
  logic             ack_q, ack_d;
  logic [DAT_W-1:0] dat_q, dat_d;
  logic             err_flag_q, err_flag_d;
  logic [ADR_W-1:0] err_adr_q, err_adr_d;

  sel_e             sel_c;
  logic             slv_ack_c;
  logic [DAT_W-1:0] slv_dat_c;
  logic             to_expire;

  assign sel_c     = decode_sel(wbs_adr_i[ADR_W-1 -: BASE_W], BRAM_BASE, UART_BASE);
  // Only the slave owning the current wait state is listened to.
  assign slv_ack_c = (state_q == BRAM_WAIT) ? wbs_ack_bram   : wbs_ack_uart;
  assign slv_dat_c = (state_q == BRAM_WAIT) ? wbs_dat_o_bram : wbs_dat_o_uart;

`ifdef WB_TIMEOUT_EN
  logic to_clr_c;
  logic to_en_c;

  assign to_clr_c = (state_q == IDLE) && ((state_d == BRAM_WAIT) || (state_d == UART_WAIT));
  assign to_en_c  = (state_q == BRAM_WAIT) || (state_q == UART_WAIT);

  wb_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES),
    .W     (TO_W)
  ) u_timeout_cnt (
    .clk_i    (wb_clk_i),
    .rst_ni   (wb_rstn_i),
    .clr_i    (to_clr_c),
    .en_i     (to_en_c),
    .expire_o (to_expire)
  );
`else
  assign to_expire = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    bram_d     = bram_q;
    uart_d     = uart_q;
    ack_d      = 1'b0;
    dat_d      = dat_q;
    err_flag_d = err_flag_q & ~err_clr_i;
    err_adr_d  = err_adr_q;

    unique case (state_q)
      IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          req_d.adr = wbs_adr_i;
          req_d.we  = wbs_we_i;
          unique case (sel_c)
            SEL_BRAM: begin
              state_d = BRAM_WAIT;
              bram_d  = 1'b1;
            end
            SEL_UART: begin
              state_d = UART_WAIT;
              uart_d  = 1'b1;
            end
            default: begin
              state_d    = ERR_ACK;
              ack_d      = 1'b1;
              dat_d      = ERR_DATA;
              err_flag_d = 1'b1;
              err_adr_d  = wbs_adr_i;
            end
          endcase
        end
      end

      BRAM_WAIT, UART_WAIT: begin
        // Master abort beats a coincident slave ack; slave ack beats timeout.
        if (!wbs_cyc_i) begin
          state_d = IDLE;
          bram_d  = 1'b0;
          uart_d  = 1'b0;
        end else if (slv_ack_c) begin
          state_d = ACK;
          bram_d  = 1'b0;
          uart_d  = 1'b0;
          ack_d   = 1'b1;
          dat_d   = req_q.we ? '0 : slv_dat_c;
        end else if (to_expire) begin
          state_d    = ERR_ACK;
          bram_d     = 1'b0;
          uart_d     = 1'b0;
          ack_d      = 1'b1;
          dat_d      = ERR_DATA;
          err_flag_d = 1'b1;
          err_adr_d  = req_q.adr;
        end
      end

      ACK, ERR_ACK: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        bram_d  = 1'b0;
        uart_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state_q    <= IDLE;
      req_q      <= '0;
      bram_q     <= 1'b0;
      uart_q     <= 1'b0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
      err_flag_q <= 1'b0;
      err_adr_q  <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      bram_q     <= bram_d;
      uart_q     <= uart_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      err_flag_q <= err_flag_d;
      err_adr_q  <= err_adr_d;
    end
  end

  assign wbs_ack_o  = ack_q;
  assign wbs_dat_o  = dat_q;
  assign cyc_bram_o = bram_q;
  assign stb_bram_o = bram_q;
  assign cyc_uart_o = uart_q;
  assign stb_uart_o = uart_q;
  assign err_flag_o = err_flag_q;
  assign err_adr_o  = err_adr_q;

endmodule

// File: tb/tb_wb_bus_ctrl.sv
// Randomized self-checking bench for wb_bus_ctrl against a per-transaction latency/data model.
module tb_wb_bus_ctrl;

  localparam int unsigned TO_CYC = 4;
  localparam int          NEVER  = 1000;
  localparam logic [31:0] ERR_D  = 32'hDEAD_BEEF;

`ifdef WB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
  logic [31:0] adr_i = '0;
  logic        ack_o;
  logic [31:0] dat_o;
  logic        cyc_bram, stb_bram, cyc_uart, stb_uart;
  logic        ack_bram = 1'b0, ack_uart = 1'b0;
  logic [31:0] dat_bram = '0, dat_uart = '0;
  logic        err_flag;
  logic [31:0] err_adr;
  logic        err_clr = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: sticky error flag and last errored address.
  logic        exp_flag = 1'b0;
  logic [31:0] exp_adr  = '0;

  always #5 clk = ~clk;

  wb_bus_ctrl #(
    .TIMEOUT_CYCLES (TO_CYC),
    .TO_W           (8)
  ) dut (
    .wb_clk_i       (clk),
    .wb_rstn_i      (rst_n),
    .wbs_cyc_i      (cyc_i),
    .wbs_stb_i      (stb_i),
    .wbs_we_i       (we_i),
    .wbs_adr_i      (adr_i),
    .wbs_ack_o      (ack_o),
    .wbs_dat_o      (dat_o),
    .cyc_bram_o     (cyc_bram),
    .stb_bram_o     (stb_bram),
    .wbs_ack_bram   (ack_bram),
    .wbs_dat_o_bram (dat_bram),
    .cyc_uart_o     (cyc_uart),
    .stb_uart_o     (stb_uart),
    .wbs_ack_uart   (ack_uart),
    .wbs_dat_o_uart (dat_uart),
    .err_flag_o     (err_flag),
    .err_adr_o      (err_adr),
    .err_clr_i      (err_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One master transaction; dly = cycle (counting from first strobe cycle) in which the slave acks.
  task automatic do_txn(input logic [31:0] adr, input logic we, input int dly,
                        input logic [31:0] sdat, input bit stray, input bit clr_same);
    int          region, lat, k;
    bit          err, got, other_hi, cyc_mis;
    logic [1:0]  stb_c1;
    logic [31:0] edat;
    region = (adr[31:20] == 12'h380) ? 0 : (adr[31:20] == 12'h300) ? 1 : 2;
    err    = (region == 2) || (TO_EN && dly > int'(TO_CYC));
    lat    = (region == 2) ? 1 : (err ? int'(TO_CYC) + 1 : dly + 1);
    edat   = err ? ERR_D : (we ? 32'h0 : sdat);
    if (clr_same) exp_flag = 1'b0;
    if (err) begin
      exp_flag = 1'b1;
      exp_adr  = adr;
    end

    @(negedge clk);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr;
    err_clr  = clr_same;
    dat_bram = sdat; dat_uart = sdat;
    ack_bram = stray && ($urandom_range(0, 1) == 1);
    ack_uart = stray && ($urandom_range(0, 1) == 1);

    got = 0; k = 0; other_hi = 0; cyc_mis = 0; stb_c1 = 2'b00;
    while (!got && k < 300) begin
      @(negedge clk);
      k++;
      err_clr = 1'b0;
      if (k == 1) stb_c1 = {stb_bram, stb_uart};
      if (region != 0 && (stb_bram || cyc_bram)) other_hi = 1;
      if (region != 1 && (stb_uart || cyc_uart)) other_hi = 1;
      if (cyc_bram !== stb_bram || cyc_uart !== stb_uart) cyc_mis = 1;
      if (ack_o) begin
        got = 1;
      end else begin
        ack_bram = (region == 0) ? (stb_bram && k == dly)
                                 : (stray && ($urandom_range(0, 1) == 1));
        ack_uart = (region == 1) ? (stb_uart && k == dly)
                                 : (stray && ($urandom_range(0, 1) == 1));
      end
    end

    check("ack_seen", 32'(got), 32'd1);
    check("latency", 32'(k), 32'(lat));
    check("ack_data", dat_o, edat);
    check("stb_at_ack", {30'd0, stb_bram, stb_uart}, 32'd0);
    check("err_flag", 32'(err_flag), 32'(exp_flag));
    check("err_adr", err_adr, exp_adr);
    check("stb_cycle1", 32'(stb_c1), {30'd0, region == 0, region == 1});
    check("other_stb", 32'(other_hi), 32'd0);
    check("cyc_eq_stb", 32'(cyc_mis), 32'd0);

    cyc_i = 1'b0; stb_i = 1'b0; ack_bram = 1'b0; ack_uart = 1'b0;
    @(negedge clk);
    check("ack_one_cycle", 32'(ack_o), 32'd0);
    check("dat_hold", dat_o, edat);
  endtask

  // Idle gap with stray slave acks and an optional clear pulse in its first cycle.
  task automatic idle_gap(input int n, input bit clr);
    for (int i = 0; i < n; i++) begin
      err_clr  = clr && (i == 0);
      ack_bram = ($urandom_range(0, 1) == 1);
      ack_uart = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (ack_o) check("idle_ack", 32'(ack_o), 32'd0);
    end
    err_clr = 1'b0; ack_bram = 1'b0; ack_uart = 1'b0;
    if (clr && n > 0) exp_flag = 1'b0;
    check("idle_flag", 32'(err_flag), 32'(exp_flag));
  endtask

  function automatic logic [31:0] rand_adr(input int region);
    logic [11:0] top;
    logic [19:0] low;
    low = 20'($urandom);
    if (region == 0) top = 12'h380;
    else if (region == 1) top = 12'h300;
    else begin
      top = 12'($urandom);
      while (top == 12'h380 || top == 12'h300) top = 12'($urandom);
    end
    return {top, low};
  endfunction

  initial begin
    bit any_ack;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_ctrl", {26'd0, ack_o, cyc_bram, stb_bram, cyc_uart, stb_uart, err_flag}, 32'd0);
    check("rst_dat", dat_o, 32'd0);
    check("rst_err_adr", err_adr, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases.
    do_txn(32'h3800_0010, 1'b0, 3, 32'h1234_5678, 1'b0, 1'b0);
    do_txn(32'h3000_0004, 1'b1, 1, 32'hCAFE_F00D, 1'b0, 1'b0);
    do_txn(32'h2600_0000, 1'b0, 1, 32'h0, 1'b0, 1'b0);
    idle_gap(1, 1'b1);
    do_txn(32'h2600_0040, 1'b0, 1, 32'h0, 1'b0, 1'b1);
    idle_gap(2, 1'b0);
    do_txn(32'h3800_0020, 1'b0, int'(TO_CYC), 32'hA5A5_5A5A, 1'b1, 1'b0);
`ifdef WB_TIMEOUT_EN
    do_txn(32'h3800_0030, 1'b0, NEVER, 32'h1111_2222, 1'b0, 1'b0);
    do_txn(32'h3000_0030, 1'b1, NEVER, 32'h3333_4444, 1'b1, 1'b0);
`else
    // No timeout: a silent slave keeps the wait state open indefinitely.
    @(negedge clk);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 32'h3800_0500;
    any_ack = 0;
    repeat (20) begin
      @(negedge clk);
      if (ack_o || !stb_bram) any_ack = 1;
    end
    check("hang_wait", 32'(any_ack), 32'd0);
    cyc_i = 1'b0; stb_i = 1'b0;
    @(negedge clk);
    check("hang_abort", {30'd0, stb_bram, ack_o}, 32'd0);
`endif

    // Master abort during BRAM_WAIT, then a late BRAM ack.
    @(negedge clk);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 32'h3800_0100;
    @(negedge clk);
    check("abort_stb_c1", 32'(stb_bram), 32'd1);
    @(negedge clk);
    cyc_i = 1'b0; stb_i = 1'b0;
    @(negedge clk);
    check("abort_stb_drop", {30'd0, cyc_bram, stb_bram}, 32'd0);
    any_ack = ack_o;
    ack_bram = 1'b1;
    repeat (3) begin
      @(negedge clk);
      any_ack |= ack_o;
    end
    ack_bram = 1'b0;
    check("abort_no_ack", 32'(any_ack), 32'd0);
    check("abort_flag", 32'(err_flag), 32'(exp_flag));

    // Randomized traffic with stray acks and clear pulses.
    for (int t = 0; t < 60; t++) begin
      int          region;
      logic [31:0] sd;
      region = $urandom_range(0, 2);
      sd     = $urandom;
      do_txn(rand_adr(region), 1'($urandom_range(0, 1)), $urandom_range(1, 7), sd,
             1'b1, ($urandom_range(0, 7) == 0));
      idle_gap($urandom_range(0, 2), ($urandom_range(0, 3) == 0));
    end

    // Reset in the middle of UART_WAIT, after leaving an error recorded.
    do_txn(32'h1000_0abc, 1'b0, 1, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 32'h3000_0008;
    @(negedge clk);
    @(negedge clk);
    check("uart_wait_stb", 32'(stb_uart), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_ctrl", {26'd0, ack_o, cyc_bram, stb_bram, cyc_uart, stb_uart, err_flag}, 32'd0);
    check("midrst_dat", dat_o, 32'd0);
    check("midrst_err_adr", err_adr, 32'd0);
    exp_flag = 1'b0;
    exp_adr  = '0;
    cyc_i = 1'b0; stb_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_txn(32'h3800_0444, 1'b0, 2, 32'h0BAD_CAFE, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
